// File: rtl/fifo_wr_ctrl.sv
// FIFO write-side controller: write pointer, fill level, full/almost-full flags and overflow tracking.
// Optional overflow event counter enabled by defining FIFO_WR_OVF_CNT_EN.
module fifo_wr_ctrl #(
    parameter int unsigned FIFO_PTR_WIDE = 3,
    parameter int unsigned AFULL_THRESH  = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    output logic                     wr_mem_en,
    output logic [FIFO_PTR_WIDE-1:0] wr_addr,
    input  logic [FIFO_PTR_WIDE:0]   rd_ptr,
    input  logic                     flush,
    output logic                     full,
    output logic                     almost_full,
    output logic [FIFO_PTR_WIDE:0]   level,
    output logic                     ovf_err,
    input  logic                     ovf_clr,
    output logic [7:0]               ovf_cnt
);

    localparam logic [FIFO_PTR_WIDE:0] AFULL_LVL = (FIFO_PTR_WIDE+1)'(AFULL_THRESH);

    logic [FIFO_PTR_WIDE:0] wr_ptr;
    logic                   ovf_evt;

    assign wr_addr = wr_ptr[FIFO_PTR_WIDE-1:0];

    // Subtraction wraps naturally in FIFO_PTR_WIDE+1 bits, giving 0..depth.
    assign level       = wr_ptr - rd_ptr;
    assign full        = (wr_ptr[FIFO_PTR_WIDE] != rd_ptr[FIFO_PTR_WIDE]) &&
                         (wr_ptr[FIFO_PTR_WIDE-1:0] == rd_ptr[FIFO_PTR_WIDE-1:0]);
    assign almost_full = (level >= AFULL_LVL);

    assign wr_ready  = !full && !flush;
    assign wr_mem_en = wr_valid && wr_ready;
    assign ovf_evt   = wr_valid && full && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= rd_ptr;
        end else if (wr_mem_en) begin
            wr_ptr <= wr_ptr + 1'b1;
        end
    end

    // Set wins over clear when both happen in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_err <= 1'b0;
        end else if (ovf_evt) begin
            ovf_err <= 1'b1;
        end else if (ovf_clr) begin
            ovf_err <= 1'b0;
        end
    end

`ifdef FIFO_WR_OVF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt <= '0;
        end else if (ovf_clr) begin
            ovf_cnt <= ovf_evt ? 8'd1 : 8'd0;
        end else if (ovf_evt && (ovf_cnt != '1)) begin
            ovf_cnt <= ovf_cnt + 8'd1;
        end
    end
`else
    assign ovf_cnt = '0;
`endif

endmodule
